// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin IF/LS sharing of one memory port with lane alignment and load extension
module mem_port_arbiter #(
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req,
    input  logic [31:0]   if_addr,
    output logic [31:0]   if_rdata,
    output logic          if_valid,
    input  logic          ls_req,
    input  logic          ls_we,
    input  logic [2:0]    ls_memi,
    input  logic [31:0]   ls_addr,
    input  logic [31:0]   ls_wdata,
    output logic [31:0]   ls_rdata,
    output logic          ls_valid,
    output logic          ls_err,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [3:0]    mem_be,
    output logic [31:0]   mem_wdata,
    input  logic          mem_gnt,
    input  logic          mem_rvalid,
    input  logic [31:0]   mem_rdata,
    output logic          stall
);
    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;
    state_t state, state_nx;
    logic last, owner, pick_ls, grant, illegal, misal, fault, resp;
    logic [2:0] memi;
    logic [1:0] off;
    logic [3:0] st_be;
    logic [7:0] ld_byte;
    logic [15:0] ld_half;
    logic [31:0] sel_addr, st_data, ld_data;
    // last = 1 means LS was served most recently, so IF wins the next tie
    always_comb begin
        pick_ls = ls_req & (~if_req | ~last);
        grant = if_req | ls_req;
        sel_addr = pick_ls ? ls_addr : if_addr;
        illegal = ls_memi[1:0] == 2'b11 || ls_memi == 3'b110;
        misal = (ls_memi[1:0] == 2'b01 && ls_addr[0]) || (ls_memi[1:0] == 2'b10 && ls_addr[1:0] != 2'b00);
        fault = pick_ls & (illegal | misal);
        st_be = ls_memi[1:0] == 2'b00 ? 4'b0001 << sel_addr[1:0] :
                ls_memi[1:0] == 2'b01 ? 4'b0011 << sel_addr[1:0] : 4'b1111;
        st_data = ls_memi[1:0] == 2'b00 ? {24'b0, ls_wdata[7:0]} << {sel_addr[1:0], 3'b000} :
                  ls_memi[1:0] == 2'b01 ? {16'b0, ls_wdata[15:0]} << {sel_addr[1:0], 3'b000} : ls_wdata;
        resp = (state == REQ && mem_gnt && mem_rvalid) || (state == RESP && mem_rvalid);
        ld_byte = 8'(mem_rdata >> {off, 3'b000});
        ld_half = off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        ld_data = memi[1:0] == 2'b00 ? {{24{~memi[2] & ld_byte[7]}}, ld_byte} :
                  memi[1:0] == 2'b01 ? {{16{~memi[2] & ld_half[15]}}, ld_half} : mem_rdata;
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: state_nx = grant ? (fault ? DONE : REQ) : IDLE;
            REQ:  state_nx = mem_gnt ? (mem_rvalid ? DONE : RESP) : REQ;
            RESP: state_nx = mem_rvalid ? DONE : RESP;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last <= 1'b0;
            owner <= 1'b0;
            memi <= 3'b000;
            off <= 2'b00;
            mem_we <= 1'b0;
            mem_addr <= '0;
            mem_be <= 4'b0000;
            mem_wdata <= 32'b0;
            if_valid <= 1'b0;
            ls_valid <= 1'b0;
            ls_err <= 1'b0;
            if_rdata <= 32'b0;
            ls_rdata <= 32'b0;
        end else begin
            if_valid <= 1'b0;
            ls_valid <= 1'b0;
            ls_err <= 1'b0;
            if (state == IDLE && grant) begin
                owner <= pick_ls;
                memi <= ls_memi;
                off <= sel_addr[1:0];
                mem_we <= pick_ls & ls_we;
                mem_addr <= AW'({sel_addr[31:2], 2'b00});
                mem_be <= pick_ls & ls_we ? st_be : 4'b1111;
                mem_wdata <= pick_ls & ls_we ? st_data : 32'b0;
                if (fault) begin
                    ls_valid <= 1'b1;
                    ls_err <= 1'b1;
                    ls_rdata <= 32'b0;
                end
            end
            if (resp && owner) begin
                ls_valid <= 1'b1;
                if (!mem_we) ls_rdata <= ld_data;
            end
            if (resp && !owner) begin
                if_valid <= 1'b1;
                if_rdata <= mem_rdata;
            end
            if (state == DONE) last <= owner;
        end
    end
    assign mem_req = state == REQ;
    assign stall = (if_req | ls_req) & ~(if_valid | ls_valid);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of arbitration, handshake timing, lanes and error path
module tb_mem_port_arbiter;
    logic clk = 1'b0, rst_n = 1'b0;
    logic if_req = 1'b0, ls_req = 1'b0, ls_we = 1'b0;
    logic [31:0] if_addr = 32'b0, ls_addr = 32'b0, ls_wdata = 32'b0, mem_rdata = 32'b0;
    logic [2:0] ls_memi = 3'b000;
    logic mem_gnt = 1'b0, mem_rvalid = 1'b0;
    logic [31:0] if_rdata, ls_rdata, mem_wdata, mem_addr;
    logic if_valid, ls_valid, ls_err, mem_req, mem_we, stall;
    logic [3:0] mem_be;
    int n_chk = 0, n_fail = 0;

    mem_port_arbiter #(.AW(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
        .ls_req(ls_req), .ls_we(ls_we), .ls_memi(ls_memi), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_rdata(ls_rdata), .ls_valid(ls_valid), .ls_err(ls_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .stall(stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // called in REQ; returns in the DONE cycle
    task automatic serve(input logic [31:0] rd, input bit same);
        mem_gnt = 1'b1;
        mem_rvalid = same;
        mem_rdata = rd;
        tick();
        mem_gnt = 1'b0;
        mem_rvalid = ~same;
        if (!same) tick();
        mem_rvalid = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " mem_req"}, 32'(mem_req), 0);
        check({tag, " mem_we"}, 32'(mem_we), 0);
        check({tag, " mem_be"}, 32'(mem_be), 0);
        check({tag, " mem_addr"}, mem_addr, 0);
        check({tag, " mem_wdata"}, mem_wdata, 0);
        check({tag, " if_valid"}, 32'(if_valid), 0);
        check({tag, " ls_valid"}, 32'(ls_valid), 0);
        check({tag, " ls_err"}, 32'(ls_err), 0);
        check({tag, " if_rdata"}, if_rdata, 0);
        check({tag, " ls_rdata"}, ls_rdata, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        tick();
        tick();
        check_all_zero("reset");
        check("reset stall", 32'(stall), 0);
        rst_n = 1'b1;
        tick();

        // fetch, gnt and rvalid in separate cycles
        if_req = 1'b1;
        if_addr = 32'h0000_0104;
        tick();
        check("fetch mem_req", 32'(mem_req), 1);
        check("fetch mem_addr", mem_addr, 32'h104);
        check("fetch mem_be", 32'(mem_be), 32'hf);
        check("fetch stall", 32'(stall), 1);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        check("fetch resp mem_req", 32'(mem_req), 0);
        check("fetch resp if_valid", 32'(if_valid), 0);
        mem_rvalid = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        tick();
        mem_rvalid = 1'b0;
        check("fetch if_valid", 32'(if_valid), 1);
        check("fetch if_rdata", if_rdata, 32'hDEAD_BEEF);
        check("fetch done stall", 32'(stall), 0);
        if_req = 1'b0;
        tick();
        check("fetch pulse end", 32'(if_valid), 0);
        check("fetch rdata hold", if_rdata, 32'hDEAD_BEEF);

        // LB at off 3 with gnt+rvalid together
        ls_req = 1'b1;
        ls_we = 1'b0;
        ls_memi = 3'b000;
        ls_addr = 32'h0000_0203;
        tick();
        check("lb mem_addr", mem_addr, 32'h200);
        check("lb mem_be", 32'(mem_be), 32'hf);
        check("lb mem_we", 32'(mem_we), 0);
        serve(32'h80FF_1234, 1'b1);
        check("lb ls_valid", 32'(ls_valid), 1);
        check("lb ls_rdata", ls_rdata, 32'hFFFF_FF80);
        check("lb ls_err", 32'(ls_err), 0);
        ls_req = 1'b0;
        tick();

        // LBU same address
        ls_req = 1'b1;
        ls_memi = 3'b100;
        tick();
        serve(32'h80FF_1234, 1'b0);
        check("lbu ls_valid", 32'(ls_valid), 1);
        check("lbu ls_rdata", ls_rdata, 32'h0000_0080);
        ls_req = 1'b0;
        tick();

        // LH at off 2: upper half, sign extended
        ls_req = 1'b1;
        ls_memi = 3'b001;
        ls_addr = 32'h0000_0222;
        tick();
        serve(32'h9ABC_0011, 1'b0);
        check("lh ls_rdata", ls_rdata, 32'hFFFF_9ABC);
        ls_req = 1'b0;
        tick();

        // SH at off 2; request fields altered after grant
        ls_req = 1'b1;
        ls_we = 1'b1;
        ls_memi = 3'b001;
        ls_addr = 32'h0000_0302;
        ls_wdata = 32'h0000_ABCD;
        tick();
        check("sh mem_be", 32'(mem_be), 32'hc);
        check("sh mem_wdata", mem_wdata, 32'hABCD_0000);
        check("sh mem_we", 32'(mem_we), 1);
        check("sh mem_addr", mem_addr, 32'h300);
        ls_addr = 32'h0000_0F01;
        ls_wdata = 32'h1111_2222;
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        check("sh latched wdata", mem_wdata, 32'hABCD_0000);
        check("sh latched be", 32'(mem_be), 32'hc);
        mem_rvalid = 1'b1;
        tick();
        mem_rvalid = 1'b0;
        check("sh ls_valid", 32'(ls_valid), 1);
        check("sh ls_err", 32'(ls_err), 0);
        ls_req = 1'b0;
        ls_we = 1'b0;
        tick();

        // SB at off 1
        ls_req = 1'b1;
        ls_we = 1'b1;
        ls_memi = 3'b000;
        ls_addr = 32'h0000_0341;
        ls_wdata = 32'h0000_0077;
        tick();
        check("sb mem_be", 32'(mem_be), 32'h2);
        check("sb mem_wdata", mem_wdata, 32'h0000_7700);
        serve(32'h0, 1'b1);
        ls_req = 1'b0;
        ls_we = 1'b0;
        tick();

        // misaligned LW and illegal memi
        ls_req = 1'b1;
        ls_memi = 3'b010;
        ls_addr = 32'h0000_0401;
        tick();
        check("lw mis ls_valid", 32'(ls_valid), 1);
        check("lw mis ls_err", 32'(ls_err), 1);
        check("lw mis mem_req", 32'(mem_req), 0);
        check("lw mis ls_rdata", ls_rdata, 0);
        ls_req = 1'b0;
        tick();
        check("lw mis pulse end", 32'(ls_valid), 0);
        check("lw mis no mem_req", 32'(mem_req), 0);
        ls_req = 1'b1;
        ls_memi = 3'b011;
        ls_addr = 32'h0000_0400;
        tick();
        check("memi011 ls_valid", 32'(ls_valid), 1);
        check("memi011 ls_err", 32'(ls_err), 1);
        check("memi011 mem_req", 32'(mem_req), 0);
        ls_req = 1'b0;
        tick();

        // fresh reset so LS wins the first tie
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        if_req = 1'b1;
        if_addr = 32'h0000_0600;
        ls_req = 1'b1;
        ls_memi = 3'b010;
        ls_addr = 32'h0000_0500;
        for (int k = 0; k < 4; k++) begin
            bit exp_ls;
            exp_ls = (k % 2) == 0;
            tick();
            check($sformatf("rr%0d mem_addr", k), mem_addr, exp_ls ? 32'h500 : 32'h600);
            check($sformatf("rr%0d req stall", k), 32'(stall), 1);
            mem_gnt = 1'b1;
            tick();
            mem_gnt = 1'b0;
            check($sformatf("rr%0d resp stall", k), 32'(stall), 1);
            mem_rvalid = 1'b1;
            mem_rdata = 32'h1000 + k;
            tick();
            mem_rvalid = 1'b0;
            check($sformatf("rr%0d ls_valid", k), 32'(ls_valid), 32'(exp_ls));
            check($sformatf("rr%0d if_valid", k), 32'(if_valid), 32'(!exp_ls));
            check($sformatf("rr%0d done stall", k), 32'(stall), 0);
            check($sformatf("rr%0d rdata", k), exp_ls ? ls_rdata : if_rdata, 32'h1000 + k);
            if (k == 3) begin
                if_req = 1'b0;
                ls_req = 1'b0;
            end
            tick();
            check($sformatf("rr%0d idle stall", k), 32'(stall), k == 3 ? 0 : 1);
        end

        // reset while in RESP, late rvalid afterwards
        if_req = 1'b1;
        if_addr = 32'h0000_0700;
        tick();
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        if_req = 1'b0;
        rst_n = 1'b0;
        tick();
        check_all_zero("midrst");
        rst_n = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata = 32'h5555_5555;
        tick();
        mem_rvalid = 1'b0;
        check("late rvalid if_valid", 32'(if_valid), 0);
        check("late rvalid ls_valid", 32'(ls_valid), 0);
        check("late rvalid mem_req", 32'(mem_req), 0);
        check("late rvalid if_rdata", if_rdata, 0);
        if_req = 1'b1;
        if_addr = 32'h0000_0800;
        tick();
        check("post rst mem_req", 32'(mem_req), 1);
        check("post rst mem_addr", mem_addr, 32'h800);
        serve(32'h1234_5678, 1'b0);
        check("post rst if_valid", 32'(if_valid), 1);
        check("post rst if_rdata", if_rdata, 32'h1234_5678);
        if_req = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
